// File: rtl/pipelined_shifter_if.sv
// Valid/ready bundle for pipelined_shifter: operation request side (in_*) and
// result side (out_*). The shifter takes the slave modport, its driver the master.
interface pipelined_shifter_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5,
   parameter int TAG_WIDTH   = 6
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  in_data;
   logic [SHAMT_WIDTH-1:0] in_shamt;
   logic [1:0]             in_op;
   logic [TAG_WIDTH-1:0]   in_tag;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_WIDTH-1:0]  out_data;
   logic [TAG_WIDTH-1:0]   out_tag;

   modport master (
      output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready, tag and flush.
// Define SHIFTER_ROTATE_EN to make op 2'b11 rotate right; otherwise it behaves as SRL.
module pipelined_shifter #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5,
   parameter int STAGES      = 2,
   parameter int TAG_WIDTH   = 6
) (
   input logic                clock,
   input logic                reset_n,
   input logic                flush,
   pipelined_shifter_if.slave bus
);
   localparam int LAST = STAGES - 1;

   typedef logic [DATA_WIDTH-1:0] data_t;

   logic                   slot_valid [STAGES];
   data_t                  slot_data  [STAGES];
   logic [SHAMT_WIDTH-1:0] slot_shamt [STAGES];
   logic [1:0]             slot_op    [STAGES];
   logic [TAG_WIDTH-1:0]   slot_tag   [STAGES];
   logic                   slot_sign  [STAGES];

   logic [STAGES-1:0]      load;
   data_t                  next_data  [STAGES];

   // Applies only the shamt bits owned by slot k; the sign comes from the original operand.
   function automatic data_t shift_slot(input int k, input data_t d,
                                        input logic [SHAMT_WIDTH-1:0] sa,
                                        input logic [1:0] op, input logic sign);
      data_t r;
      data_t fill;
      int    w;
      r = d;
      for (int b = 0; b < SHAMT_WIDTH; b++) begin
         w    = 1 << b;
         fill = ~({DATA_WIDTH{1'b1}} >> w);
         if ((((b * STAGES) / SHAMT_WIDTH) == k) && sa[b]) begin
            case (op)
               2'b00:   r = r << w;
               2'b10:   r = (r >> w) | (sign ? fill : '0);
`ifdef SHIFTER_ROTATE_EN
               2'b11:   r = (r >> w) | (r << (DATA_WIDTH - w));
`endif
               default: r = r >> w;
            endcase
         end
      end
      return r;
   endfunction

   // load[k]: slot k may take new content, i.e. it is empty or its occupant moves on.
   always_comb begin
      logic chain;
      chain = bus.out_ready;
      load  = '0;
      for (int k = LAST; k >= 0; k--) begin
         chain   = !slot_valid[k] || chain;
         load[k] = chain;
      end
   end

   always_comb begin
      next_data[0] = shift_slot(0, bus.in_data, bus.in_shamt, bus.in_op,
                                bus.in_data[DATA_WIDTH-1]);
      for (int k = 1; k < STAGES; k++) begin
         next_data[k] = shift_slot(k, slot_data[k-1], slot_shamt[k-1],
                                   slot_op[k-1], slot_sign[k-1]);
      end
   end

   assign bus.in_ready  = !flush && load[0];
   assign bus.out_valid = slot_valid[LAST];
   assign bus.out_data  = slot_data[LAST];
   assign bus.out_tag   = slot_tag[LAST];

   // Payload registers load only behind a valid occupant, so idle X never enters a slot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            slot_valid[k] <= 1'b0;
            slot_data[k]  <= '0;
            slot_shamt[k] <= '0;
            slot_op[k]    <= '0;
            slot_tag[k]   <= '0;
            slot_sign[k]  <= 1'b0;
         end
      end else begin
         if (flush) begin
            slot_valid[0] <= 1'b0;
         end else if (load[0]) begin
            slot_valid[0] <= bus.in_valid;
         end
         if (bus.in_valid && bus.in_ready) begin
            slot_data[0]  <= next_data[0];
            slot_shamt[0] <= bus.in_shamt;
            slot_op[0]    <= bus.in_op;
            slot_tag[0]   <= bus.in_tag;
            slot_sign[0]  <= bus.in_data[DATA_WIDTH-1];
         end
         for (int k = 1; k < STAGES; k++) begin
            if (flush) begin
               slot_valid[k] <= 1'b0;
            end else if (load[k]) begin
               slot_valid[k] <= slot_valid[k-1];
            end
            if (load[k] && slot_valid[k-1]) begin
               slot_data[k]  <= next_data[k];
               slot_shamt[k] <= slot_shamt[k-1];
               slot_op[k]    <= slot_op[k-1];
               slot_tag[k]   <= slot_tag[k-1];
               slot_sign[k]  <= slot_sign[k-1];
            end
         end
      end
   end
endmodule
